// File: rtl/usb4_tc_noc_fifo_pkg.sv
// Shared defaults for the NoC link FIFO controller and its pointer sub-block.
package usb4_tc_noc_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 37;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the address.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb4_tc_noc_fifo_ptr.sv
// Wrapping RAM pointer: increments modulo 2**AW, cleared synchronously by flush.
module usb4_tc_noc_fifo_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/usb4_tc_noc_fifo_ctrl_8_37.sv
// FIFO controller beside an external 2-port RAM: pointers, occupancy, high-water mark
// and valid/ready handshakes. Data storage lives entirely in the parent's RAM.
module usb4_tc_noc_fifo_ctrl_8_37
    import usb4_tc_noc_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic [AW:0]      hwm,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_ren,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    // Handshake: a transfer happens on a rising clk edge where valid && ready.
    // in_ready and out_valid depend only on registered state and flush, so there
    // is no combinational path from out_ready to in_ready; a full FIFO popped in
    // a cycle accepts its next push one cycle later.

    logic [AW:0]   count_q, count_d;
    logic [AW:0]   hwm_q, hwm_d;
    logic          push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign in_ready  = !flush && (count_q != FULL_CNT);
    assign out_valid = !flush && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    usb4_tc_noc_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    usb4_tc_noc_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (pop && !push) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            hwm_q   <= '0;
        end else begin
            count_q <= count_d;
            hwm_q   <= hwm_d;
        end
    end

    assign count     = count_q;
    assign hwm       = hwm_q;
    assign ram_wen   = push;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = in_data;
    assign ram_ren   = out_valid;
    assign ram_raddr = rd_ptr;
    assign out_data  = ram_rdata;

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_q != FULL_CNT));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count_q != '0));
    a_no_x_hs: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({in_valid, out_ready}));

endmodule

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_37.sv
// Directed bench for the FIFO controller with a behavioural 8x37 RAM beside it.
module tb_usb4_tc_noc_fifo_ctrl_8_37;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] out_data;
    logic [3:0]  count;
    logic [3:0]  hwm;
    logic        ram_wen;
    logic [2:0]  ram_waddr;
    logic [36:0] ram_wdata;
    logic        ram_ren;
    logic [2:0]  ram_raddr;
    logic [36:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [36:0] mem [8];

    usb4_tc_noc_fifo_ctrl_8_37 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .hwm       (hwm),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = ram_ren ? mem[ram_raddr] : '1;

    // Inputs change 1ns after a rising edge; outputs are sampled 4ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [36:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        #4;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%b%b exp=00", ram_wen, ram_ren); end
        checks++; if (count !== 4'd0 || hwm !== 4'd0) begin errors++; $display("FAIL reset_count_hwm got=%0d/%0d exp=0/0", count, hwm); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 37'(i + 1), 1'b0, 1'b0);
            checks++; if (ram_wen !== 1'b1 || ram_waddr !== 3'(i)) begin errors++; $display("FAIL fill_write[%0d] got wen=%b addr=%0d exp wen=1 addr=%0d", i, ram_wen, ram_waddr, i); end
            checks++; if (out_valid !== (i != 0)) begin errors++; $display("FAIL fill_out_valid[%0d] got=%b exp=%b", i, out_valid, (i != 0)); end
            next_cycle();
        end
        drive(1'b1, 37'h9, 1'b0, 1'b0);
        checks++; if (count !== 4'd8 || hwm !== 4'd8) begin errors++; $display("FAIL fill_count_hwm got=%0d/%0d exp=8/8", count, hwm); end
        checks++; if (in_ready !== 1'b0 || ram_wen !== 1'b0) begin errors++; $display("FAIL fill_ninth got ready=%b wen=%b exp 0/0", in_ready, ram_wen); end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_hold got=%0d exp=8", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_data !== 37'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, i + 1); end
            checks++; if (count !== 4'(8 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 8 - i); end
            next_cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || count !== 4'd0 || hwm !== 4'd8) begin errors++; $display("FAIL drain_end got v=%b cnt=%0d hwm=%0d exp 0/0/8", out_valid, count, hwm); end
        next_cycle();
    endtask

    // Pointers start at 0; 20 pushes wrap the write pointer twice.
    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 37'h100 + 37'(i), 1'b1, 1'b0);
            checks++; if (ram_waddr !== 3'(i % 8) || ram_wen !== 1'b1) begin errors++; $display("FAIL stream_waddr[%0d] got=%0d wen=%b exp=%0d", i, ram_waddr, ram_wen, i % 8); end
            if (i > 0) begin
                checks++; if (count !== 4'd1 || out_data !== 37'h100 + 37'(i - 1) || ram_raddr !== 3'((i - 1) % 8)) begin errors++; $display("FAIL stream_pop[%0d] got cnt=%0d d=%h ra=%0d exp cnt=1 d=%h ra=%0d", i, count, out_data, ram_raddr, 37'h100 + 37'(i - 1), (i - 1) % 8); end
            end
            next_cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_data !== 37'h113 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_last got v=%b d=%h exp v=1 d=113", out_valid, out_data); end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== 4'd0 || hwm !== 4'd8) begin errors++; $display("FAIL stream_end got cnt=%0d hwm=%0d exp 0/8", count, hwm); end
    endtask

    task automatic test_full_pop();
        logic [36:0] exp_d [8];
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 37'h200 + 37'(i), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 37'h2aa, 1'b1, 1'b0);
        checks++; if (count !== 4'd8 || ram_wen !== 1'b0 || out_data !== 37'h200) begin errors++; $display("FAIL full_pop got cnt=%0d wen=%b d=%h exp 8/0/200", count, ram_wen, out_data); end
        next_cycle();
        drive(1'b1, 37'h2aa, 1'b0, 1'b0);
        checks++; if (count !== 4'd7 || ram_wen !== 1'b1 || ram_waddr !== 3'd4) begin errors++; $display("FAIL full_repush got cnt=%0d wen=%b wa=%0d exp 7/1/4", count, ram_wen, ram_waddr); end
        next_cycle();
        for (int i = 0; i < 7; i++) exp_d[i] = 37'h201 + 37'(i);
        exp_d[7] = 37'h2aa;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            if (i == 0) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill got=%0d exp=8", count); end
            end
            checks++; if (out_data !== exp_d[i]) begin errors++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, out_data, exp_d[i]); end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 37'h300 + 37'(i), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 37'h3ff, 1'b1, 1'b1);
        checks++; if (count !== 4'd5 || hwm !== 4'd8) begin errors++; $display("FAIL flush_pre got cnt=%0d hwm=%0d exp 5/8", count, hwm); end
        checks++; if (ram_wen !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_gate got wen=%b rdy=%b v=%b exp 000", ram_wen, in_ready, out_valid); end
        next_cycle();
        drive(1'b1, 37'h3a5, 1'b0, 1'b0);
        checks++; if (count !== 4'd0 || hwm !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_post got cnt=%0d hwm=%0d v=%b exp 0/0/0", count, hwm, out_valid); end
        checks++; if (ram_waddr !== 3'd0 || ram_wen !== 1'b1) begin errors++; $display("FAIL flush_waddr got=%0d wen=%b exp 0/1", ram_waddr, ram_wen); end
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== 4'd1 || hwm !== 4'd1 || out_data !== 37'h3a5 || ram_raddr !== 3'd0) begin errors++; $display("FAIL flush_after got cnt=%0d hwm=%0d d=%h ra=%0d exp 1/1/3a5/0", count, hwm, out_data, ram_raddr); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 37'h400 + 37'(i), 1'b1, 1'b0);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_nobypass got=%b exp=0", out_valid); end
            end
            drive(1'b1, 37'h400 + 37'(i), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== 4'd3 || ram_raddr !== 3'd1) begin errors++; $display("FAIL mid_pre got cnt=%0d ra=%0d exp 3/1", count, ram_raddr); end
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || hwm !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ram_ren !== 1'b0) begin errors++; $display("FAIL mid_async got cnt=%0d hwm=%0d v=%b rdy=%b ren=%b exp 0/0/0/1/0", count, hwm, out_valid, in_ready, ram_ren); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        drive(1'b1, 37'h1234, 1'b0, 1'b0);
        checks++; if (ram_wen !== 1'b1 || ram_waddr !== 3'd0) begin errors++; $display("FAIL mid_first_push got wen=%b wa=%0d exp 1/0", ram_wen, ram_waddr); end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 37'h1234 || count !== 4'd1) begin errors++; $display("FAIL mid_readback got v=%b d=%h cnt=%0d exp 1/1234/1", out_valid, out_data, count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_pop();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
